// File: rtl/pc_next_gen.sv
// pc_next_gen: IF-stage next-address generator.
// Chooses between hold, live redirect, buffered redirect and sequential
// increment; buffers a redirect seen while fetch is frozen and raises a
// timed IF/ID flush after every redirect that actually reaches the PC.
//
// Handshake note: there is no valid/ready pair on this block. A redirect
// request (BranchTaken/Jump) is a single-cycle pulse and is consumed on the
// edge where it is sampled: applied when fetch is not frozen, otherwise
// captured into the pending register. Fetch advances only when
// ImemReady=1 and Stall=0.
module pc_next_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] Address,
  output logic        Flush,
  output logic        RedirectPending,
  output logic        MisalignErr,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [31:0] STEP       = 32'(PC_STEP);

  // Pending-redirect FSM. Flushing is tracked by flush_cnt, orthogonal to it.
  typedef enum logic {
    RUN       = 1'b0,
    HOLD_PEND = 1'b1
  } pend_state_t;

  pend_state_t state;
  pend_state_t state_nxt;

  logic [31:0] pend_target;
  logic        pend_is_branch;
  logic [2:0]  flush_cnt;
  logic        mis_flag;

  logic        freeze;
  logic        req_valid;
  logic        req_is_branch;
  logic [31:0] req_raw;
  logic [31:0] req_target;
  logic        req_misalign;

  logic        pend_load;
  logic        apply;
  logic        set_mis;

  // Decode the incoming request: branch wins over jump, low bits dropped.
  always_comb begin
    freeze        = Stall | ~ImemReady;
    req_valid     = BranchTaken | Jump;
    req_is_branch = BranchTaken;
    req_raw       = BranchTaken ? BranchTarget : JumpTarget;
    req_target    = {req_raw[31:2], 2'b00};
    req_misalign  = req_valid & (req_raw[1:0] != 2'b00);
  end

  // Next-state logic: decide whether to capture, apply or keep waiting.
  always_comb begin
    state_nxt = state;
    pend_load = 1'b0;
    apply     = 1'b0;
    case (state)
      RUN: begin
        if (req_valid && freeze) begin
          pend_load = 1'b1;
          state_nxt = HOLD_PEND;
        end else if (req_valid) begin
          apply = 1'b1;
        end
      end
      HOLD_PEND: begin
        if (!freeze) begin
          // Either the live request or the buffered one goes out; a live
          // request simply replaces the buffered target.
          apply     = 1'b1;
          state_nxt = RUN;
        end else if (req_valid && (req_is_branch || !pend_is_branch)) begin
          // A branch replaces anything; a jump never replaces a branch.
          pend_load = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    set_mis = req_misalign & (pend_load | (apply & req_valid));
  end

  // Address mux in strict priority: reset, hold, live, pending, sequential.
  always_comb begin
    Address = PCResult + STEP;
    if (!Reset) begin
      Address = RESET_VECTOR;
    end else if (freeze) begin
      Address = PCResult;
    end else if (req_valid) begin
      Address = req_target;
    end else if (state == HOLD_PEND) begin
      Address = pend_target;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending redirect storage, written only when a request is captured.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend_target    <= 32'h0;
      pend_is_branch <= 1'b0;
    end else if (pend_load) begin
      pend_target    <= req_target;
      pend_is_branch <= req_is_branch;
    end
  end

  // Flush countdown: reload on every applied redirect, else count to zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      flush_cnt <= 3'd0;
    end else if (apply) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (flush_cnt != 3'd0) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mis_flag <= 1'b0;
    end else if (set_mis) begin
      mis_flag <= 1'b1;
    end
  end

  // Status outputs; dbg_state = {flushing, holding a pending redirect}.
  always_comb begin
    Flush           = (flush_cnt != 3'd0);
    RedirectPending = (state == HOLD_PEND);
    MisalignErr     = mis_flag;
    dbg_state       = {Flush, RedirectPending};
  end

endmodule

// File: tb/tb_pc_next_gen.sv
// tb_pc_next_gen: directed bench for pc_next_gen with a behavioural model
// and a per-cycle compare process plus literal checks at key points.
module tb_pc_next_gen;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          FLUSH = 2;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCResult;
  logic        Stall;
  logic        ImemReady;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] Address;
  logic        Flush;
  logic        RedirectPending;
  logic        MisalignErr;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;
  bit track   = 1'b0;

  pc_next_gen #(
    .RESET_VECTOR(RV),
    .FLUSH_CYCLES(FLUSH),
    .PC_STEP(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PCResult(PCResult),
    .Stall(Stall),
    .ImemReady(ImemReady),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump(Jump),
    .JumpTarget(JumpTarget),
    .Address(Address),
    .Flush(Flush),
    .RedirectPending(RedirectPending),
    .MisalignErr(MisalignErr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] target;
    bit          is_branch;
  } redir_t;

  redir_t pend_q[$];
  int     m_flush_left = 0;
  bit     m_mis = 1'b0;

  function automatic logic [31:0] m_addr();
    if (!Reset) return RV;
    if (Stall || !ImemReady) return PCResult;
    if (BranchTaken) return BranchTarget & 32'hFFFF_FFFC;
    if (Jump) return JumpTarget & 32'hFFFF_FFFC;
    if (pend_q.size() != 0) return pend_q[0].target;
    return PCResult + 32'd4;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend_q.delete();
      m_flush_left = 0;
      m_mis = 1'b0;
    end else begin
      bit frozen;
      bit have_req;
      bit req_mis;
      redir_t req;
      frozen     = Stall || !ImemReady;
      have_req   = BranchTaken || Jump;
      req.is_branch = BranchTaken;
      req.target = (BranchTaken ? BranchTarget : JumpTarget) & 32'hFFFF_FFFC;
      req_mis    = BranchTaken ? (BranchTarget % 4 != 0) : (JumpTarget % 4 != 0);
      if (m_flush_left > 0) m_flush_left--;
      if (!frozen) begin
        if (have_req || pend_q.size() != 0) m_flush_left = FLUSH;
        if (have_req && req_mis) m_mis = 1'b1;
        pend_q.delete();
      end else if (have_req) begin
        if (pend_q.size() == 0 || BranchTaken || !pend_q[0].is_branch) begin
          pend_q.delete();
          pend_q.push_back(req);
          if (req_mis) m_mis = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge Clk) begin
    if (run_cmp) begin
      chk("cmp_addr", Address, m_addr());
      chk("cmp_flush", {31'b0, Flush}, {31'b0, (m_flush_left > 0)});
      chk("cmp_pend", {31'b0, RedirectPending}, {31'b0, (pend_q.size() != 0)});
      chk("cmp_mis", {31'b0, MisalignErr}, {31'b0, m_mis});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge Clk);
    #1;
  endtask

  task automatic advance();
    logic [31:0] a;
    a = Address;
    @(posedge Clk);
    #1;
    if (track) PCResult = a;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b0; PCResult = RV; Stall = 1'b0; ImemReady = 1'b1;
    BranchTaken = 1'b0; BranchTarget = 32'h0; Jump = 1'b0; JumpTarget = 32'h0;
    track = 1'b1;
    run_cmp = 1'b1;

    // Reset and sequential fetch with PCResult following Address.
    settle();
    chk("rst_addr", Address, 32'h0);
    chk("rst_flush", {31'b0, Flush}, 32'h0);
    chk("rst_pend", {31'b0, RedirectPending}, 32'h0);
    chk("rst_mis", {31'b0, MisalignErr}, 32'h0);
    advance();
    advance();
    Reset = 1'b1;
    settle(); chk("seq_4", Address, 32'h4); advance();
    settle(); chk("seq_8", Address, 32'h8); advance();
    settle(); chk("seq_c", Address, 32'hC);
    chk("seq_flush", {31'b0, Flush}, 32'h0);
    advance();

    // Branch redirect and two-cycle flush.
    track = 1'b0;
    PCResult = 32'h10; BranchTaken = 1'b1; BranchTarget = 32'h40;
    settle(); chk("br_addr", Address, 32'h40); chk("br_flush0", {31'b0, Flush}, 32'h0);
    advance();
    BranchTaken = 1'b0; PCResult = 32'h40;
    settle(); chk("br_flush1", {31'b0, Flush}, 32'h1); chk("br_next", Address, 32'h44);
    advance();
    PCResult = 32'h44;
    settle(); chk("br_flush2", {31'b0, Flush}, 32'h1);
    advance();
    settle(); chk("br_flush_end", {31'b0, Flush}, 32'h0);
    advance();

    // Jump during stall is buffered then applied.
    PCResult = 32'h20; Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h80;
    settle(); chk("st_hold1", Address, 32'h20); chk("st_pend0", {31'b0, RedirectPending}, 32'h0);
    advance();
    Jump = 1'b0;
    settle(); chk("st_hold2", Address, 32'h20); chk("st_pend1", {31'b0, RedirectPending}, 32'h1);
    advance();
    settle(); chk("st_hold3", Address, 32'h20);
    advance();
    Stall = 1'b0;
    settle(); chk("st_apply", Address, 32'h80); chk("st_pend_still", {31'b0, RedirectPending}, 32'h1);
    advance();
    PCResult = 32'h80;
    settle(); chk("st_pend_clr", {31'b0, RedirectPending}, 32'h0); chk("st_next", Address, 32'h84);
    chk("st_flush", {31'b0, Flush}, 32'h1);
    advance(); advance();

    // Branch beats jump; misaligned branch target.
    BranchTaken = 1'b1; BranchTarget = 32'h100; Jump = 1'b1; JumpTarget = 32'h200;
    settle(); chk("prio_addr", Address, 32'h100);
    advance();
    BranchTarget = 32'h102;
    settle(); chk("mis_addr", Address, 32'h100); chk("mis_before", {31'b0, MisalignErr}, 32'h0);
    advance();
    BranchTaken = 1'b0; Jump = 1'b0;
    settle(); chk("mis_set", {31'b0, MisalignErr}, 32'h1);
    advance();

    // Back-to-back redirects reload the flush counter.
    BranchTaken = 1'b1; BranchTarget = 32'h300;
    advance();
    BranchTarget = 32'h340;
    advance();
    BranchTaken = 1'b0;
    settle(); chk("reload_f1", {31'b0, Flush}, 32'h1); advance();
    settle(); chk("reload_f2", {31'b0, Flush}, 32'h1); advance();
    settle(); chk("reload_f3", {31'b0, Flush}, 32'h0); advance();

    // Wrap-around and ImemReady hold.
    PCResult = 32'hFFFF_FFFC;
    settle(); chk("wrap", Address, 32'h0); advance();
    ImemReady = 1'b0;
    settle(); chk("imem_hold1", Address, 32'hFFFF_FFFC); advance();
    settle(); chk("imem_hold2", Address, 32'hFFFF_FFFC); advance();
    ImemReady = 1'b1;

    // Pending overwrite rules.
    PCResult = 32'h1000; Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h300;
    advance();
    Jump = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h400;
    advance();
    BranchTaken = 1'b0; Jump = 1'b1; JumpTarget = 32'h500;
    advance();
    Jump = 1'b0; Stall = 1'b0;
    settle(); chk("ovr_br_kept", Address, 32'h400); advance();
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h600;
    advance();
    JumpTarget = 32'h700;
    advance();
    Jump = 1'b0; Stall = 1'b0;
    settle(); chk("ovr_jmp_jmp", Address, 32'h700); advance();
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h800;
    advance();
    Jump = 1'b0; Stall = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h900;
    settle(); chk("live_over", Address, 32'h900); advance();
    BranchTaken = 1'b0;
    settle(); chk("live_discard", Address, 32'h1004);
    chk("live_pend0", {31'b0, RedirectPending}, 32'h0);
    advance(); advance();

    // Reset mid-flush with a pending redirect: immediate clear.
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'hA00;
    advance();
    Jump = 1'b0; Stall = 1'b0;
    advance();
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'hB00;
    settle(); chk("pre_rst_flush", {31'b0, Flush}, 32'h1);
    @(posedge Clk);
    #1;
    Jump = 1'b0;
    #1;
    chk("pre_rst_pend", {31'b0, RedirectPending}, 32'h1);
    Reset = 1'b0;
    #1;
    chk("async_addr", Address, RV);
    chk("async_flush", {31'b0, Flush}, 32'h0);
    chk("async_pend", {31'b0, RedirectPending}, 32'h0);
    chk("async_mis", {31'b0, MisalignErr}, 32'h0);
    Stall = 1'b0; PCResult = RV;
    advance(); advance();
    Reset = 1'b1;
    settle(); chk("post_rst", Address, RV + 32'd4);
    advance();

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_gen.md
Name: pc_next_gen

Overview:
- Next-address generator that drives the Address input of the program counter register and consumes its PCResult output.
- Selects the next fetch address from sequential increment, branch redirect, jump redirect, or hold.
- Buffers a redirect that arrives while fetch is frozen, and issues a timed IF/ID flush after every applied redirect.
- Sits in the IF stage between the PC register, instruction memory and the EX-stage branch/jump resolution.

Parameters:
- RESET_VECTOR, 32'h00000000, address driven during and after reset.
- FLUSH_CYCLES, 2, number of cycles Flush stays high after a redirect is applied (1..7).
- PC_STEP, 4, sequential increment in bytes.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PCResult  input  32  current PC register value.
- Stall  input  1  hazard-unit stall; holds the PC.
- ImemReady  input  1  instruction memory has accepted the fetch at PCResult.
- BranchTaken  input  1  one-cycle pulse, branch resolved taken.
- BranchTarget  input  32  branch target, valid with BranchTaken.
- Jump  input  1  one-cycle pulse, jump resolved.
- JumpTarget  input  32  jump target, valid with Jump.
- Address  output  32  next PC value to the PC register.
- Flush  output  1  squash IF/ID contents.
- RedirectPending  output  1  a buffered redirect is waiting.
- MisalignErr  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset low, asynchronous: Address = RESET_VECTOR, Flush = 0, RedirectPending = 0, MisalignErr = 0, flush counter = 0, pending register cleared.
- Freeze = Stall OR NOT ImemReady.
- Redirect request: BranchTaken has priority over Jump when both are high in the same cycle. Targets are used with bits [1:0] forced to 0.
- Address is combinational from the registered state and the current inputs, chosen in this priority order:
  1. Freeze: Address = PCResult (hold).
  2. Not frozen and a redirect request this cycle: Address = request target. A live request overrides any pending one, which is discarded.
  3. Not frozen and RedirectPending: Address = pending target; RedirectPending clears at the edge.
  4. Otherwise: Address = PCResult + PC_STEP, mod 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
- Redirect arriving while frozen: captured into the pending register at the edge; RedirectPending = 1 from the next cycle.
- Request arriving while already pending, still frozen:
  - A branch overwrites a pending jump or branch.
  - A jump overwrites only a pending jump.
- FSM states:
  - RUN: default.
  - HOLD_PEND: pending redirect held while frozen.
  - FLUSHING: counter nonzero.
  - FLUSHING and RUN/HOLD_PEND are orthogonal; the flush counter is independent of the pending register.
- Flush counter:
  - Loaded with FLUSH_CYCLES at the edge where a redirect is applied (case 2 or 3).
  - Flush = (counter != 0), registered, so Flush rises the cycle after the redirect is applied.
  - Counter decrements every cycle, including frozen cycles.
  - A new redirect applied while counting reloads it to FLUSH_CYCLES.
- MisalignErr sets at the edge where a misaligned target is captured or applied; cleared only by reset.
- Reset asserted mid-flush or mid-pending: all state cleared immediately; the first post-reset Address is RESET_VECTOR + PC_STEP.

Test Plan:
- Reset low, then high with PCResult tracking Address → Address sequence 0x0, 0x4, 0x8, 0xC; Flush = 0 throughout.
- PCResult = 0x10, one-cycle BranchTaken with BranchTarget = 0x40 → Address = 0x40 in that cycle; Flush high for exactly 2 cycles starting the next cycle; then Address = 0x44.
- Stall high 3 cycles at PCResult = 0x20, Jump with JumpTarget = 0x80 in stall cycle 1 → Address = 0x20 while stalled; RedirectPending = 1; first unstalled cycle Address = 0x80; RedirectPending clears.
- BranchTaken (0x100) and Jump (0x200) in the same unfrozen cycle → Address = 0x100; MisalignErr stays 0. Repeat with BranchTarget = 0x102 → Address = 0x100; MisalignErr = 1 until reset.
- PCResult = 0xFFFFFFFC, no redirect → Address = 0x00000000. ImemReady low 2 cycles → Address held at PCResult.
- Pending jump set, then Reset pulsed low mid-flush → Address = RESET_VECTOR, Flush = 0, RedirectPending = 0 immediately, with no clock edge required.
